// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write and load-control signals of imem_loader.
// master = host/boot source side, slave = the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_rst_n;

  modport master (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata, busy, done, err, cpu_rst_n
  );

  modport slave (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata, busy, done, err, cpu_rst_n
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words, writes them to
// instruction memory from address 0, then releases the core reset. Optional
// trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK = 3'd3,
`endif
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] NO_WORDS  = {(ADDR_W+1){1'b0}};

  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] n);
    if (n > MAX_WORDS) begin
      return MAX_WORDS;
    end else begin
      return n;
    end
  endfunction

  state_t              state_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W:0]     remaining_r;
  logic [1:0]          byte_idx_r;
  logic [DATA_W-1:0]   word_r;
  logic                byte_ready_r;
  logic                im_we_r;
  logic [ADDR_W-1:0]   im_addr_r;
  logic [DATA_W-1:0]   im_wdata_r;
  logic                busy_r;
  logic                done_r;
  logic                cpu_rst_n_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic                err_r;
  logic [7:0]          xor_r;
`endif

  logic                hs_s;
  logic [DATA_W-1:0]   packed_s;

  assign hs_s     = bus.byte_valid & byte_ready_r;
  assign packed_s = {word_r[DATA_W-9:0], bus.byte_data};

  // Loader FSM; every output is registered and set for the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      addr_r       <= {ADDR_W{1'b0}};
      remaining_r  <= NO_WORDS;
      byte_idx_r   <= 2'd0;
      word_r       <= {DATA_W{1'b0}};
      byte_ready_r <= 1'b0;
      im_we_r      <= 1'b0;
      im_addr_r    <= {ADDR_W{1'b0}};
      im_wdata_r   <= {DATA_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      cpu_rst_n_r  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      err_r        <= 1'b0;
      xor_r        <= 8'h00;
`endif
    end else begin
      im_we_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (bus.start) begin
            addr_r     <= {ADDR_W{1'b0}};
            byte_idx_r <= 2'd0;
            word_r     <= {DATA_W{1'b0}};
`ifdef IMEM_LOADER_CHECKSUM_EN
            err_r      <= 1'b0;
            xor_r      <= 8'h00;
`endif
            if (bus.word_count != NO_WORDS) begin
              remaining_r  <= clamp_count(bus.word_count);
              state_r      <= RECV;
              byte_ready_r <= 1'b1;
              busy_r       <= 1'b1;
              done_r       <= 1'b0;
              cpu_rst_n_r  <= 1'b0;
            end else begin
              state_r      <= DONE;
              byte_ready_r <= 1'b0;
              busy_r       <= 1'b0;
              done_r       <= 1'b1;
              cpu_rst_n_r  <= 1'b1;
            end
          end else begin
            state_r <= state_r;
          end
        end
        RECV: begin
          if (hs_s) begin
            word_r <= packed_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_r  <= xor_r ^ bus.byte_data;
`endif
            if (byte_idx_r == 2'd3) begin
              byte_idx_r   <= 2'd0;
              state_r      <= WRITE;
              byte_ready_r <= 1'b0;
              im_we_r      <= 1'b1;
              im_addr_r    <= addr_r;
              im_wdata_r   <= packed_s;
            end else begin
              byte_idx_r <= byte_idx_r + 2'd1;
            end
          end else begin
            state_r <= RECV;
          end
        end
        WRITE: begin
          remaining_r <= remaining_r - ONE_WORD;
          // Address only advances when another word follows, so a full load never wraps
          if (remaining_r == ONE_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_r      <= CHECK;
            byte_ready_r <= 1'b1;
`else
            state_r      <= DONE;
            busy_r       <= 1'b0;
            done_r       <= 1'b1;
            cpu_rst_n_r  <= 1'b1;
`endif
          end else begin
            addr_r       <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_r      <= RECV;
            byte_ready_r <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (hs_s) begin
            state_r      <= DONE;
            byte_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b1;
            err_r        <= (xor_r != bus.byte_data);
            cpu_rst_n_r  <= (xor_r == bus.byte_data);
          end else begin
            state_r <= CHECK;
          end
        end
`endif
        default: begin
          state_r      <= IDLE;
          byte_ready_r <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
          cpu_rst_n_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_r;
  assign bus.im_we      = im_we_r;
  assign bus.im_addr    = im_addr_r;
  assign bus.im_wdata   = im_wdata_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.cpu_rst_n  = cpu_rst_n_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.err        = err_r;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-cycle vector table plus multi-cycle
// sequences (backpressure, full-capacity clamp, mid-load reset, checksum).
module tb_imem_loader;

  logic clk;
  logic rst_n;
  int   n_err;
  int   n_checks;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  typedef struct {
    logic        start;
    logic [8:0]  count;
    logic        valid;
    logic [7:0]  data;
    logic        exp_ready;
    logic        exp_we;
    logic [7:0]  exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_crst;
  } vec_t;

  logic [7:0]  stim [0:1024];
  logic [7:0]  wr_addr [$];
  logic [31:0] wr_data [$];

  function automatic vec_t mk(input logic s, input logic [8:0] c, input logic v, input logic [7:0] d,
                              input logic r, input logic we, input logic [7:0] a, input logic [31:0] wd,
                              input logic b, input logic dn, input logic cr);
    vec_t t;
    t.start = s; t.count = c; t.valid = v; t.data = d;
    t.exp_ready = r; t.exp_we = we; t.exp_addr = a; t.exp_wdata = wd;
    t.exp_busy = b; t.exp_done = dn; t.exp_crst = cr;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic rec();
    if (bus.im_we === 1'b1) begin
      wr_addr.push_back(bus.im_addr);
      wr_data.push_back(bus.im_wdata);
    end
  endtask

  task automatic do_start(input logic [8:0] count);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.word_count = count;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  // Offer stim[0..n-1]; a byte advances only after a cycle where valid and ready were both high
  task automatic stream(input int n, input bit rnd, input int budget);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < n && cyc < budget) begin
      @(negedge clk);
      rec();
      bus.byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.byte_data  = stim[idx];
      acc = bus.byte_valid && bus.byte_ready;
      @(posedge clk);
      if (acc) idx++;
      cyc++;
    end
    @(negedge clk);
    rec();
    bus.byte_valid = 1'b0;
    check("stream_all_bytes_taken", 32'(idx), 32'(n));
  endtask

  task automatic wait_done(input int budget);
    int cyc = 0;
    while (bus.done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      rec();
      cyc++;
    end
    check("done_within_budget", 32'(bus.done), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_we"},    32'(bus.im_we), 32'd0);
    check({tag, "_addr"},  32'(bus.im_addr), 32'd0);
    check({tag, "_wdata"}, bus.im_wdata, 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_done"},  32'(bus.done), 32'd0);
    check({tag, "_err"},   32'(bus.err), 32'd0);
    check({tag, "_crst"},  32'(bus.cpu_rst_n), 32'd0);
  endtask

  vec_t vecs [0:14];

  initial begin
    n_err = 0;
    n_checks = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.word_count = 9'd0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;

    //            st   cnt    v    data   rdy we  addr   wdata         busy done crst
    vecs[0]  = mk(1'b1, 9'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
    vecs[1]  = mk(1'b1, 9'd2, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 9'd2, 1'b1, 8'h20, 1'b1, 1'b0, 8'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 9'd2, 1'b0, 8'hFF, 1'b1, 1'b0, 8'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 9'd2, 1'b1, 8'h08, 1'b1, 1'b0, 8'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 9'd5, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 9'd2, 1'b1, 8'h00, 1'b1, 1'b0, 8'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 9'd2, 1'b1, 8'h05, 1'b0, 1'b1, 8'd0, 32'h2008_0005, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 9'd2, 1'b1, 8'hAA, 1'b1, 1'b0, 8'd0, 32'h2008_0005, 1'b1, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 9'd2, 1'b1, 8'hAA, 1'b1, 1'b0, 8'd0, 32'h2008_0005, 1'b1, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 9'd2, 1'b1, 8'hBB, 1'b1, 1'b0, 8'd0, 32'h2008_0005, 1'b1, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 9'd2, 1'b1, 8'hCC, 1'b1, 1'b0, 8'd0, 32'h2008_0005, 1'b1, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 9'd2, 1'b1, 8'hDD, 1'b0, 1'b1, 8'd1, 32'hAABB_CCDD, 1'b1, 1'b0, 1'b0);
    vecs[13] = mk(1'b0, 9'd2, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 32'hAABB_CCDD, 1'b0, 1'b1, 1'b1);
    vecs[14] = mk(1'b0, 9'd2, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1, 32'hAABB_CCDD, 1'b0, 1'b1, 1'b1);

    // Reset values
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

`ifndef IMEM_LOADER_CHECKSUM_EN
    // Zero count, restart from DONE, two words with bubble, ignored start, held byte
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.start      = vecs[i].start;
      bus.word_count = vecs[i].count;
      bus.byte_valid = vecs[i].valid;
      bus.byte_data  = vecs[i].data;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ready", i), 32'(bus.byte_ready), 32'(vecs[i].exp_ready));
      check($sformatf("v%0d_we", i),    32'(bus.im_we),      32'(vecs[i].exp_we));
      check($sformatf("v%0d_addr", i),  32'(bus.im_addr),    32'(vecs[i].exp_addr));
      check($sformatf("v%0d_wdata", i), bus.im_wdata,        vecs[i].exp_wdata);
      check($sformatf("v%0d_busy", i),  32'(bus.busy),       32'(vecs[i].exp_busy));
      check($sformatf("v%0d_done", i),  32'(bus.done),       32'(vecs[i].exp_done));
      check($sformatf("v%0d_crst", i),  32'(bus.cpu_rst_n),  32'(vecs[i].exp_crst));
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
`endif

    // Backpressure: three words with random valid
    for (int i = 0; i < 12; i++) stim[i] = 8'hA0 + 8'(i);
    stim[12] = 8'h00;
    wr_addr.delete();
    wr_data.delete();
    do_start(9'd3);
    check("bp_busy", 32'(bus.busy), 32'd1);
    check("bp_crst_low", 32'(bus.cpu_rst_n), 32'd0);
    check("bp_done_low", 32'(bus.done), 32'd0);
    stream(12 + EXTRA, 1'b1, 400);
    wait_done(20);
    check("bp_nwrites", 32'(wr_addr.size()), 32'd3);
    if (wr_addr.size() == 3) begin
      check("bp_addr0", 32'(wr_addr[0]), 32'd0);
      check("bp_addr1", 32'(wr_addr[1]), 32'd1);
      check("bp_addr2", 32'(wr_addr[2]), 32'd2);
      check("bp_data0", wr_data[0], 32'hA0A1_A2A3);
      check("bp_data1", wr_data[1], 32'hA4A5_A6A7);
      check("bp_data2", wr_data[2], 32'hA8A9_AAAB);
    end
    check("bp_crst_high", 32'(bus.cpu_rst_n), 32'd1);

    // Oversized count clamps to the full 256 words, ending at the last address
    for (int i = 0; i < 1024; i++) stim[i] = 8'(i);
    stim[1024] = 8'h00;
    wr_addr.delete();
    wr_data.delete();
    do_start(9'h1FF);
    stream(1024 + EXTRA, 1'b0, 3000);
    wait_done(20);
    check("clamp_nwrites", 32'(wr_addr.size()), 32'd256);
    if (wr_addr.size() == 256) begin
      check("clamp_data1", wr_data[1], 32'h0405_0607);
      check("clamp_last_addr", 32'(wr_addr[255]), 32'd255);
      check("clamp_last_data", wr_data[255], 32'hFCFD_FEFF);
    end
    check("clamp_addr_hold", 32'(bus.im_addr), 32'd255);
    check("clamp_busy", 32'(bus.busy), 32'd0);

    // Reset after two bytes, then reload a single word
    wr_addr.delete();
    wr_data.delete();
    stim[0] = 8'hDE;
    stim[1] = 8'hAD;
    do_start(9'd1);
    stream(2, 1'b0, 20);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    stim[0] = 8'h01; stim[1] = 8'h23; stim[2] = 8'h45; stim[3] = 8'h67; stim[4] = 8'h00;
    do_start(9'd1);
    stream(4 + EXTRA, 1'b0, 40);
    wait_done(20);
    check("midrst_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("midrst_addr", 32'(wr_addr[0]), 32'd0);
      check("midrst_data", wr_data[0], 32'h0123_4567);
    end
    check("midrst_crst", 32'(bus.cpu_rst_n), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good then bad
    stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'h03; stim[3] = 8'h04; stim[4] = 8'h04;
    do_start(9'd1);
    stream(5, 1'b0, 40);
    wait_done(20);
    check("cks_good_err", 32'(bus.err), 32'd0);
    check("cks_good_crst", 32'(bus.cpu_rst_n), 32'd1);
    stim[4] = 8'h05;
    do_start(9'd1);
    check("cks_restart_err", 32'(bus.err), 32'd0);
    stream(5, 1'b0, 40);
    wait_done(20);
    check("cks_bad_err", 32'(bus.err), 32'd1);
    check("cks_bad_crst", 32'(bus.cpu_rst_n), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
